// File: rtl/alu_rs_pkg.sv
// Shared ALU reservation-station constants, opcode encoding, entry layout and CDB snoop helper.
package alu_rs_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int ROB_W    = 4;
  localparam int OPENUM_W = 5;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [OPENUM_W-1:0] {
    OP_NOP = 5'd0, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT,
    OP_BGE, OP_BLTU, OP_BGEU
  } openum_t;

  typedef struct packed {
    logic              busy;
    openum_t           openum;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [ROB_W-1:0]  q1;
    logic [ROB_W-1:0]  q2;
    logic              q1_busy;
    logic              q2_busy;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
    logic [ROB_W-1:0]  rob_id;
  } rs_entry_t;

  typedef struct packed {
    logic              busy;
    logic [DATA_W-1:0] val;
  } operand_t;

  // ALU broadcast wins when both buses carry the awaited tag.
  function automatic operand_t snoop(
    input logic busy, input logic [DATA_W-1:0] val, input logic [ROB_W-1:0] q,
    input logic a_vld, input logic [ROB_W-1:0] a_tag, input logic [DATA_W-1:0] a_val,
    input logic l_vld, input logic [ROB_W-1:0] l_tag, input logic [DATA_W-1:0] l_val);
    operand_t r;
    r.busy = busy;
    r.val  = val;
    if (busy && a_vld && a_tag == q) begin
      r.busy = 1'b0;
      r.val  = a_val;
    end else if (busy && l_vld && l_tag == q) begin
      r.busy = 1'b0;
      r.val  = l_val;
    end
    return r;
  endfunction
endpackage

// File: rtl/alu_rs_select.sv
// Combinational priority encoders: lowest free entry and lowest ready entry, zero latency.
module rs_select #(
  parameter int N = 16
) (
  input  logic [N-1:0]         busy,
  input  logic [N-1:0]         ready,
  output logic [$clog2(N)-1:0] free_idx,
  output logic                 free_vld,
  output logic [$clog2(N)-1:0] ready_idx,
  output logic                 ready_vld
);
  always_comb begin
    free_idx  = '0;
    free_vld  = 1'b0;
    ready_idx = '0;
    ready_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = ($clog2(N))'(i);
        free_vld = 1'b1;
      end
      if (ready[i]) begin
        ready_idx = ($clog2(N))'(i);
        ready_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch-to-issue 2 edges, one issue/cycle; rs_full refuses dispatch, rdy_in=0 freezes.
// RS_FAST_WAKEUP_EN lets a CDB-woken entry issue at the same edge with forwarded operands.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic              jump_wrong,
  input  logic              dispatch_en,
  input  openum_t           dispatch_openum,
  input  logic [DATA_W-1:0] dispatch_V1,
  input  logic [DATA_W-1:0] dispatch_V2,
  input  logic [ROB_W-1:0]  dispatch_Q1,
  input  logic [ROB_W-1:0]  dispatch_Q2,
  input  logic              dispatch_Q1_busy,
  input  logic              dispatch_Q2_busy,
  input  logic [DATA_W-1:0] dispatch_imm,
  input  logic [ADDR_W-1:0] dispatch_pc,
  input  logic [ROB_W-1:0]  dispatch_rob_id,
  output logic              rs_full,
  input  logic              alu_cdb_valid,
  input  logic [ROB_W-1:0]  alu_cdb_rob_id,
  input  logic [DATA_W-1:0] alu_cdb_value,
  input  logic              lsb_cdb_valid,
  input  logic [ROB_W-1:0]  lsb_cdb_rob_id,
  input  logic [DATA_W-1:0] lsb_cdb_value,
  output openum_t           alu_openum,
  output logic [DATA_W-1:0] alu_V1,
  output logic [DATA_W-1:0] alu_V2,
  output logic [DATA_W-1:0] alu_imm,
  output logic [ADDR_W-1:0] alu_pc,
  output logic [ROB_W-1:0]  alu_rob_id
);
  localparam int IDX_W = $clog2(RS_SIZE);

  rs_entry_t          rs [RS_SIZE];
  rs_entry_t          wk [RS_SIZE];
  rs_entry_t          disp;
  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   ready_idx;
  logic               free_vld;
  logic               ready_vld;

  // wk holds each entry as it will look after this cycle's CDB snoop.
  always_comb begin
    operand_t op;
    for (int i = 0; i < RS_SIZE; i++) begin
      wk[i] = rs[i];
      op = snoop(rs[i].q1_busy, rs[i].v1, rs[i].q1, alu_cdb_valid, alu_cdb_rob_id,
                 alu_cdb_value, lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
      wk[i].q1_busy = op.busy;
      wk[i].v1      = op.val;
      op = snoop(rs[i].q2_busy, rs[i].v2, rs[i].q2, alu_cdb_valid, alu_cdb_rob_id,
                 alu_cdb_value, lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
      wk[i].q2_busy = op.busy;
      wk[i].v2      = op.val;
      busy_vec[i]   = rs[i].busy;
`ifdef RS_FAST_WAKEUP_EN
      ready_vec[i]  = rs[i].busy && !wk[i].q1_busy && !wk[i].q2_busy;
`else
      ready_vec[i]  = rs[i].busy && !rs[i].q1_busy && !rs[i].q2_busy;
`endif
    end
  end

  always_comb begin
    operand_t op;
    disp.busy   = 1'b1;
    disp.openum = dispatch_openum;
    disp.q1     = dispatch_Q1;
    disp.q2     = dispatch_Q2;
    disp.imm    = dispatch_imm;
    disp.pc     = dispatch_pc;
    disp.rob_id = dispatch_rob_id;
    op = snoop(dispatch_Q1_busy, dispatch_V1, dispatch_Q1, alu_cdb_valid, alu_cdb_rob_id,
               alu_cdb_value, lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
    disp.q1_busy = op.busy;
    disp.v1      = op.val;
    op = snoop(dispatch_Q2_busy, dispatch_V2, dispatch_Q2, alu_cdb_valid, alu_cdb_rob_id,
               alu_cdb_value, lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
    disp.q2_busy = op.busy;
    disp.v2      = op.val;
  end

  rs_select #(.N(RS_SIZE)) u_select (
    .busy      (busy_vec),
    .ready     (ready_vec),
    .free_idx  (free_idx),
    .free_vld  (free_vld),
    .ready_idx (ready_idx),
    .ready_vld (ready_vld)
  );

  assign rs_full = !free_vld;

  // Free index comes from pre-issue state, so an issuing slot is never reused in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) rs[i] <= '0;
      alu_openum <= OP_NOP;
      alu_V1     <= ZERO_WORD;
      alu_V2     <= ZERO_WORD;
      alu_imm    <= ZERO_WORD;
      alu_pc     <= '0;
      alu_rob_id <= '0;
    end else if (rdy_in) begin
      if (jump_wrong) begin
        for (int i = 0; i < RS_SIZE; i++) rs[i].busy <= 1'b0;
        alu_openum <= OP_NOP;
        alu_V1     <= ZERO_WORD;
        alu_V2     <= ZERO_WORD;
        alu_imm    <= ZERO_WORD;
        alu_pc     <= '0;
        alu_rob_id <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) rs[i] <= wk[i];
        if (ready_vld) begin
          rs[ready_idx].busy <= 1'b0;
          alu_openum <= wk[ready_idx].openum;
          alu_V1     <= wk[ready_idx].v1;
          alu_V2     <= wk[ready_idx].v2;
          alu_imm    <= wk[ready_idx].imm;
          alu_pc     <= wk[ready_idx].pc;
          alu_rob_id <= wk[ready_idx].rob_id;
        end else begin
          alu_openum <= OP_NOP;
          alu_V1     <= ZERO_WORD;
          alu_V2     <= ZERO_WORD;
          alu_imm    <= ZERO_WORD;
          alu_pc     <= '0;
          alu_rob_id <= '0;
        end
        if (dispatch_en && free_vld) rs[free_idx] <= disp;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs; wakeup-timing expectations follow RS_FAST_WAKEUP_EN.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy_in, jump_wrong, dispatch_en;
  openum_t     dispatch_openum;
  logic [31:0] dispatch_V1, dispatch_V2, dispatch_imm, dispatch_pc;
  logic [3:0]  dispatch_Q1, dispatch_Q2, dispatch_rob_id;
  logic        dispatch_Q1_busy, dispatch_Q2_busy;
  logic        rs_full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_id, lsb_cdb_rob_id;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  openum_t     alu_openum;
  logic [31:0] alu_V1, alu_V2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_id;

  int total = 0;
  int bad   = 0;

`ifdef RS_FAST_WAKEUP_EN
  localparam int WAKE_DELAY = 0;
`else
  localparam int WAKE_DELAY = 1;
`endif

  alu_rs #(.RS_SIZE(16)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .jump_wrong(jump_wrong),
    .dispatch_en(dispatch_en), .dispatch_openum(dispatch_openum),
    .dispatch_V1(dispatch_V1), .dispatch_V2(dispatch_V2),
    .dispatch_Q1(dispatch_Q1), .dispatch_Q2(dispatch_Q2),
    .dispatch_Q1_busy(dispatch_Q1_busy), .dispatch_Q2_busy(dispatch_Q2_busy),
    .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc), .dispatch_rob_id(dispatch_rob_id),
    .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id), .lsb_cdb_value(lsb_cdb_value),
    .alu_openum(alu_openum), .alu_V1(alu_V1), .alu_V2(alu_V2), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob_id(alu_rob_id)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    jump_wrong = 1'b0; dispatch_en = 1'b0; dispatch_openum = OP_NOP;
    dispatch_V1 = '0; dispatch_V2 = '0; dispatch_Q1 = '0; dispatch_Q2 = '0;
    dispatch_Q1_busy = 1'b0; dispatch_Q2_busy = 1'b0;
    dispatch_imm = '0; dispatch_pc = '0; dispatch_rob_id = '0;
    alu_cdb_valid = 1'b0; alu_cdb_rob_id = '0; alu_cdb_value = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
  endtask

  task automatic set_disp(input openum_t op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic q1b, input logic [3:0] q1,
                          input logic q2b, input logic [3:0] q2, input logic [3:0] rob);
    dispatch_en = 1'b1; dispatch_openum = op; dispatch_V1 = v1; dispatch_V2 = v2;
    dispatch_Q1_busy = q1b; dispatch_Q1 = q1; dispatch_Q2_busy = q2b; dispatch_Q2 = q2;
    dispatch_rob_id = rob; dispatch_imm = 32'h100 + 32'(rob); dispatch_pc = 32'h4000 + 32'(rob);
  endtask

  task automatic test_reset;
    total++; if (alu_openum !== OP_NOP) begin bad++; $display("FAIL reset_op got=%0d want=%0d", alu_openum, OP_NOP); end
    total++; if (alu_V1 !== 32'h0 || alu_V2 !== 32'h0) begin bad++; $display("FAIL reset_v got=%h/%h want=0/0", alu_V1, alu_V2); end
    total++; if (alu_imm !== 32'h0 || alu_pc !== 32'h0 || alu_rob_id !== 4'h0) begin bad++; $display("FAIL reset_misc got=%h/%h/%h want=0", alu_imm, alu_pc, alu_rob_id); end
    total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", rs_full); end
  endtask

  task automatic test_ready_dispatch;
    set_disp(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick; idle;
    total++; if (alu_openum !== OP_NOP) begin bad++; $display("FAIL ready_early got=%0d want=%0d", alu_openum, OP_NOP); end
    tick;
    total++; if (alu_openum !== OP_ADD || alu_V1 !== 32'd5 || alu_V2 !== 32'd7 || alu_rob_id !== 4'd3)
      begin bad++; $display("FAIL ready_issue got=%0d/%0d/%0d/%0d want=%0d/5/7/3", alu_openum, alu_V1, alu_V2, alu_rob_id, OP_ADD); end
    total++; if (alu_imm !== 32'h103 || alu_pc !== 32'h4003) begin bad++; $display("FAIL ready_imm_pc got=%h/%h want=103/4003", alu_imm, alu_pc); end
    tick;
    total++; if (alu_openum !== OP_NOP) begin bad++; $display("FAIL ready_after got=%0d want=%0d", alu_openum, OP_NOP); end
  endtask

  task automatic test_wakeup;
    set_disp(OP_SUB, 32'd0, 32'd2, 1'b1, 4'd6, 1'b0, 4'd0, 4'd4);
    tick; idle;
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd6; alu_cdb_value = 32'h10;
    tick; idle;
    if (WAKE_DELAY == 1) begin
      total++; if (alu_openum !== OP_NOP) begin bad++; $display("FAIL wake_early got=%0d want=%0d", alu_openum, OP_NOP); end
      tick;
    end
    total++; if (alu_openum !== OP_SUB || alu_V1 !== 32'h10 || alu_V2 !== 32'd2 || alu_rob_id !== 4'd4)
      begin bad++; $display("FAIL wake_issue got=%0d/%h/%h/%0d want=%0d/10/2/4", alu_openum, alu_V1, alu_V2, alu_rob_id, OP_SUB); end
    tick;
  endtask

  task automatic test_cdb_priority;
    int k;
    set_disp(OP_OR, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd6);
    tick; idle;
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd2; alu_cdb_value = 32'h111;
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd2; lsb_cdb_value = 32'h222;
    tick; idle;
    for (k = 0; k < 3 && alu_openum === OP_NOP; k++) tick;
    total++; if (alu_openum !== OP_OR || alu_V1 !== 32'h111)
      begin bad++; $display("FAIL cdb_prio got=%0d/%h want=%0d/111", alu_openum, alu_V1, OP_OR); end
    tick;
  endtask

  task automatic test_full;
    int nxt;
    int first_k;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL full_at15 got=%b want=0", rs_full); end
      end
      set_disp(OP_ADD, 32'd0, 32'(i), 1'b1, 4'd7, 1'b0, 4'd0, 4'(i));
      tick;
    end
    total++; if (rs_full !== 1'b1) begin bad++; $display("FAIL full_at16 got=%b want=1", rs_full); end
    set_disp(OP_XOR, 32'd0, 32'd0, 1'b1, 4'd8, 1'b0, 4'd0, 4'd15);
    tick; idle;
    total++; if (rs_full !== 1'b1) begin bad++; $display("FAIL full_17th got=%b want=1", rs_full); end
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd8; alu_cdb_value = 32'h99;
    tick; idle; tick;
    total++; if (alu_openum !== OP_NOP) begin bad++; $display("FAIL full_ignored got=%0d want=%0d", alu_openum, OP_NOP); end
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd7; alu_cdb_value = 32'h20;
    tick; idle;
    nxt = 0; first_k = -1;
    for (int k = 0; k < 20; k++) begin
      if (alu_openum !== OP_NOP) begin
        if (first_k < 0) begin
          first_k = k;
          total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL full_freed got=%b want=0", rs_full); end
        end
        total++; if (alu_rob_id !== 4'(nxt) || alu_V1 !== 32'h20 || alu_V2 !== 32'(nxt))
          begin bad++; $display("FAIL full_drain got=%0d/%h/%0d want=%0d/20/%0d", alu_rob_id, alu_V1, alu_V2, nxt, nxt); end
        nxt++;
      end else if (first_k < 0) begin
        total++; if (rs_full !== 1'b1) begin bad++; $display("FAIL full_before_issue got=%b want=1", rs_full); end
      end
      tick;
    end
    total++; if (first_k !== WAKE_DELAY) begin bad++; $display("FAIL full_first_issue got=%0d want=%0d", first_k, WAKE_DELAY); end
    total++; if (nxt !== 16) begin bad++; $display("FAIL full_count got=%0d want=16", nxt); end
  endtask

  task automatic test_bypass;
    set_disp(OP_XOR, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd5);
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd9; lsb_cdb_value = 32'hAB;
    tick; idle; tick;
    total++; if (alu_openum !== OP_XOR || alu_V1 !== 32'd1 || alu_V2 !== 32'hAB || alu_rob_id !== 4'd5)
      begin bad++; $display("FAIL bypass got=%0d/%h/%h/%0d want=%0d/1/ab/5", alu_openum, alu_V1, alu_V2, alu_rob_id, OP_XOR); end
    tick;
  endtask

  task automatic test_flush;
    for (int i = 0; i < 4; i++) begin
      set_disp(OP_AND, 32'd0, 32'd3, 1'b1, 4'd7, 1'b0, 4'd0, 4'(i));
      tick;
    end
    set_disp(OP_ADD, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
    jump_wrong = 1'b1;
    tick; idle;
    total++; if (alu_openum !== OP_NOP) begin bad++; $display("FAIL flush_op got=%0d want=%0d", alu_openum, OP_NOP); end
    total++; if (rs_full !== 1'b0) begin bad++; $display("FAIL flush_full got=%b want=0", rs_full); end
    alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd7; alu_cdb_value = 32'h5;
    for (int k = 0; k < 3; k++) begin
      tick; idle;
      total++; if (alu_openum !== OP_NOP) begin bad++; $display("FAIL flush_empty_%0d got=%0d want=%0d", k, alu_openum, OP_NOP); end
    end
  endtask

  task automatic test_freeze;
    set_disp(OP_SLL, 32'h33, 32'h44, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    tick;
    set_disp(OP_SRL, 32'h55, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
    tick; idle;
    total++; if (alu_openum !== OP_SLL || alu_rob_id !== 4'd9) begin bad++; $display("FAIL freeze_pre got=%0d/%0d want=%0d/9", alu_openum, alu_rob_id, OP_SLL); end
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++; if (alu_openum !== OP_SLL || alu_rob_id !== 4'd9 || alu_V1 !== 32'h33)
        begin bad++; $display("FAIL freeze_hold_%0d got=%0d/%0d/%h want=%0d/9/33", k, alu_openum, alu_rob_id, alu_V1, OP_SLL); end
    end
    rdy_in = 1'b1;
    tick;
    total++; if (alu_openum !== OP_SRL || alu_rob_id !== 4'd10 || alu_V2 !== 32'h66)
      begin bad++; $display("FAIL freeze_resume got=%0d/%0d/%h want=%0d/10/66", alu_openum, alu_rob_id, alu_V2, OP_SRL); end
    tick;
  endtask

  task automatic test_reset_mid;
    set_disp(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    tick;
    set_disp(OP_SUB, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
    tick; idle;
    #2 rst = 1'b1;
    #1;
    total++; if (alu_openum !== OP_NOP || alu_V1 !== 32'h0 || alu_rob_id !== 4'h0)
      begin bad++; $display("FAIL rst_async got=%0d/%h/%0d want=%0d/0/0", alu_openum, alu_V1, alu_rob_id, OP_NOP); end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      total++; if (alu_openum !== OP_NOP) begin bad++; $display("FAIL rst_discard_%0d got=%0d want=%0d", k, alu_openum, OP_NOP); end
    end
  endtask

  initial begin
    rst = 1'b1; rdy_in = 1'b1; idle;
    #12;
    test_reset;
    rst = 1'b0;
    tick;
    test_ready_dispatch;
    test_wakeup;
    test_cdb_priority;
    test_bypass;
    test_full;
    test_flush;
    test_freeze;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter: RS_SIZE, default 16, number of reservation-station entries; power of two, at least 2.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 rdy_in  in  1  global enable; low freezes all state, including output registers.
REQ-005 jump_wrong  in  1  misprediction flush.
REQ-006 dispatch_en  in  1  decoder writes one instruction this cycle.
REQ-007 dispatch_openum  in  OPENUM width  ALU operation code.
REQ-008 dispatch_V1/dispatch_V2  in  32 each  operand values, valid when the matching Q busy bit is low.
REQ-009 dispatch_Q1/dispatch_Q2  in  ROB-id width each  producer tags.
REQ-010 dispatch_Q1_busy/dispatch_Q2_busy  in  1 each  operand still pending.
REQ-011 dispatch_imm, dispatch_pc  in  32 each; dispatch_rob_id  in  ROB-id width.
REQ-012 rs_full  out  1  no free entry.
REQ-013 alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value  in  1/ROB-id/32  ALU broadcast.
REQ-014 lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value  in  1/ROB-id/32  load-store broadcast.
REQ-015 alu_openum, alu_V1, alu_V2, alu_imm, alu_pc, alu_rob_id  out  OPENUM/32/32/32/32/ROB-id  registered issue to ALU; alu_openum = NOP means no issue.

Function
REQ-016 Each entry SHALL hold: busy, openum, V1, V2, Q1, Q2, Q1_busy, Q2_busy, imm, pc, rob_id.
REQ-017 rs_full SHALL be combinational from current state: high iff all RS_SIZE entries are busy.
REQ-018 Dispatch SHALL write the lowest-index free entry when dispatch_en=1 and rs_full=0; when rs_full=1 the dispatch is ignored.
- An entry issued in the same cycle does not create space for that cycle's dispatch.
REQ-019 Dispatch bypass: if a dispatched Qx_busy=1 tag matches a valid CDB tag in the same cycle, the entry SHALL store that CDB value with Qx_busy=0.
REQ-020 Wakeup: each busy entry whose pending Qx matches a valid CDB tag SHALL capture the value and clear Qx_busy at the edge.
- If both CDBs carry the same tag, the ALU CDB value takes priority.
REQ-021 Ready condition: busy=1, Q1_busy=0 and Q2_busy=0.
REQ-022 Select/issue: each edge, the lowest-index ready entry SHALL be copied into the alu_* registers and its busy bit cleared at the same edge; with no ready entry, alu_openum SHALL be NOP and the other alu_* outputs zero.
REQ-023 At most one issue per cycle.
REQ-024 Latency: an entry dispatched with both operands ready at edge N SHALL appear on the alu_* outputs after edge N+1.
REQ-025 jump_wrong=1 at an edge SHALL clear all busy bits and set alu_openum to NOP.
- Flush takes priority over dispatch, wakeup and issue in that cycle.
REQ-026 rdy_in=0 SHALL hold every register; jump_wrong is honoured only when rdy_in=1.

Reset
REQ-027 rst=1 SHALL immediately clear all entry busy bits, alu_openum=NOP, and alu_V1/V2/imm/pc/rob_id=0; rs_full=0 follows from the cleared state.
REQ-028 Reset asserted mid-operation SHALL discard all entries with no partial issue.

Configuration
REQ-029 Macro RS_FAST_WAKEUP_EN, when defined: an entry made ready by a CDB match in cycle N SHALL be eligible for selection at edge N, with the CDB value forwarded into alu_V1/alu_V2.
REQ-030 When RS_FAST_WAKEUP_EN is undefined: that entry SHALL be eligible at edge N+1 at the earliest.
- Dispatch bypass (REQ-019) is present in both builds.

Structure
REQ-031 OPENUM codes including NOP, DATA/ADDR widths, ROB-id width and ZERO_WORD SHALL live in the shared constants package; RS_SIZE stays local.
REQ-032 Sub-module rs_select SHALL be a combinational priority encoder producing the lowest free index, the lowest ready index and their valid flags.

Verification
REQ-033 The bench SHALL cover the following scenarios:
- Ready-operand dispatch: dispatch ADD V1=5, V2=7, rob_id=3, both ready -> after edge N+1, alu_openum=ADD, alu_V1=5, alu_V2=7, alu_rob_id=3; next cycle alu_openum=NOP.
- Wakeup: dispatch SUB with Q1_busy=1, Q1=6, then alu_cdb tag 6, value 0x10 -> entry issues with alu_V1=0x10, one cycle earlier with RS_FAST_WAKEUP_EN than without.
- Full: fill 16 entries with Q1_busy=1 -> rs_full=1; a 17th dispatch is ignored; a CDB wake plus issue frees one slot -> rs_full=0 next cycle.
- Same-cycle bypass: dispatch with Q2=9 busy while lsb_cdb tag 9, value 0xAB -> entry stores V2=0xAB, issues without further wakeup.
- Flush: 4 busy entries plus simultaneous dispatch and jump_wrong=1 -> all entries empty, alu_openum=NOP, rs_full=0.
- Freeze: rdy_in=0 for 3 cycles with a ready entry -> no issue, outputs held; issue occurs on the first edge after rdy_in=1.
